// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: register byte offsets and the
// word-index decode used by the bus-facing logic.
package gpio_pkg;

    localparam int REG_IDX_W = 10;

    localparam logic [11:0] GPIO_OUT_OFS      = 12'h000;
    localparam logic [11:0] GPIO_DIR_OFS      = 12'h004;
    localparam logic [11:0] GPIO_IN_OFS       = 12'h008;
    localparam logic [11:0] GPIO_IRQ_EN_OFS   = 12'h00C;
    localparam logic [11:0] GPIO_IRQ_STAT_OFS = 12'h010;
    localparam logic [11:0] GPIO_SET_OFS      = 12'h014;
    localparam logic [11:0] GPIO_CLR_OFS      = 12'h018;

    typedef enum logic [2:0] {
        REG_OUT,
        REG_DIR,
        REG_IN,
        REG_IRQ_EN,
        REG_IRQ_STAT,
        REG_SET,
        REG_CLR,
        REG_NONE
    } gpio_reg_e;

    // Word index (addr[11:2]) to register; unmapped offsets fall to REG_NONE.
    function automatic gpio_reg_e decode_reg(input logic [REG_IDX_W-1:0] idx);
        gpio_reg_e sel;
        case (idx)
            GPIO_OUT_OFS[11:2]:      sel = REG_OUT;
            GPIO_DIR_OFS[11:2]:      sel = REG_DIR;
            GPIO_IN_OFS[11:2]:       sel = REG_IN;
            GPIO_IRQ_EN_OFS[11:2]:   sel = REG_IRQ_EN;
            GPIO_IRQ_STAT_OFS[11:2]: sel = REG_IRQ_STAT;
            GPIO_SET_OFS[11:2]:      sel = REG_SET;
            GPIO_CLR_OFS[11:2]:      sel = REG_CLR;
            default:                 sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_if.sv
// Single-port peripheral bus between the address decoder / core and the GPIO block.
interface gpio_if;
    logic        cs_n;
    logic        we;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output cs_n,
        output we,
        output addr,
        output be,
        output wdata,
        input  rdata
    );

    modport slave (
        input  cs_n,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer for asynchronous pin inputs plus a history flop so a
// rising edge is seen as a one-cycle pulse on the synchronized level.
module gpio_sync_edge #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_reg;
    logic [W-1:0] s2_reg;
    logic [W-1:0] prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            prev_reg <= '0;
        end else begin
            s1_reg   <= async_in;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
        end
    end

    assign level = s2_reg;
    assign rise  = s2_reg & ~prev_reg;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: byte-masked OUT/DIR/IRQ_EN registers, SET/CLR aliases,
// W1C interrupt status fed by synchronized rising edges, one-cycle read latency.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int N_GPIO = 16
) (
    input  logic              clk,
    input  logic              reset,
    gpio_if.slave             bus,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq
);

    logic [N_GPIO-1:0] out_reg,  out_next;
    logic [N_GPIO-1:0] dir_reg,  dir_next;
    logic [N_GPIO-1:0] en_reg,   en_next;
    logic [N_GPIO-1:0] stat_reg, stat_next;
    logic [31:0]       rdata_reg;
    logic              irq_reg;

    logic [N_GPIO-1:0] in_sync;
    logic [N_GPIO-1:0] in_rise;

    logic [31:0]       be_mask;
    logic [N_GPIO-1:0] wmask;
    logic [N_GPIO-1:0] wbits;
    logic [N_GPIO-1:0] w1c;
    logic              wr_en;
    logic              rd_en;
    gpio_reg_e         sel;
    logic [31:0]       rd_val;
    logic              unused_bits;

    gpio_sync_edge #(.W(N_GPIO)) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .async_in (gpio_in),
        .level    (in_sync),
        .rise     (in_rise)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_mask
            assign be_mask[8*gi +: 8] = {8{bus.be[gi]}};
        end
    endgenerate

    // Register bits above N_GPIO do not exist, so their write data is dropped here.
    assign wmask = be_mask[N_GPIO-1:0];
    assign wbits = bus.wdata[N_GPIO-1:0] & wmask;
    assign wr_en = ~bus.cs_n & bus.we;
    assign rd_en = ~bus.cs_n & ~bus.we;
    assign sel   = decode_reg(bus.addr[11:2]);

    assign unused_bits = ^{bus.addr[1:0], bus.wdata, be_mask};

    always_comb begin
        out_next = out_reg;
        dir_next = dir_reg;
        en_next  = en_reg;
        w1c      = '0;
        if (wr_en) begin
            case (sel)
                REG_OUT:      out_next = (out_reg & ~wmask) | wbits;
                REG_DIR:      dir_next = (dir_reg & ~wmask) | wbits;
                REG_IRQ_EN:   en_next  = (en_reg  & ~wmask) | wbits;
                REG_IRQ_STAT: w1c      = wbits;
                REG_SET:      out_next = out_reg | wbits;
                REG_CLR:      out_next = out_reg & ~wbits;
                default:      ;
            endcase
        end
        // A fresh enabled edge outranks a simultaneous clear of the same bit.
        stat_next = (in_rise & en_reg) | (stat_reg & ~w1c);
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_OUT:      rd_val = 32'(out_reg);
            REG_DIR:      rd_val = 32'(dir_reg);
            REG_IN:       rd_val = 32'(in_sync);
            REG_IRQ_EN:   rd_val = 32'(en_reg);
            REG_IRQ_STAT: rd_val = 32'(stat_reg);
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg   <= '0;
            dir_reg   <= '0;
            en_reg    <= '0;
            stat_reg  <= '0;
            rdata_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            out_reg  <= out_next;
            dir_reg  <= dir_next;
            en_reg   <= en_next;
            stat_reg <= stat_next;
            irq_reg  <= |(stat_next & en_next);
            if (rd_en) begin
                rdata_reg <= rd_val;
            end
        end
    end

    assign bus.rdata = rdata_reg;
    assign gpio_out  = out_reg;
    assign gpio_oe   = dir_reg;
    assign irq       = irq_reg;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: directed register-map scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_gpio_ctrl;

    localparam int N_GPIO = 16;
    localparam logic [31:0] PIN_MASK = (32'd1 << N_GPIO) - 32'd1;

    localparam logic [11:0] A_OUT  = 12'h000;
    localparam logic [11:0] A_DIR  = 12'h004;
    localparam logic [11:0] A_IN   = 12'h008;
    localparam logic [11:0] A_EN   = 12'h00C;
    localparam logic [11:0] A_STAT = 12'h010;
    localparam logic [11:0] A_SET  = 12'h014;
    localparam logic [11:0] A_CLR  = 12'h018;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_GPIO-1:0] gpio_in;
    logic [N_GPIO-1:0] gpio_out;
    logic [N_GPIO-1:0] gpio_oe;
    logic              irq;

    gpio_if bus_if ();

    gpio_ctrl #(.N_GPIO(N_GPIO)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if.slave),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register values as plain words, and the pin history as
    // a list of past samples (newest first). IN is the sample from two edges back.
    logic [31:0] m_out = '0, m_dir = '0, m_en = '0, m_stat = '0, m_rdata = '0;
    logic        m_irq = 1'b0;
    logic [31:0] samp_q[$] = '{32'h0, 32'h0, 32'h0};

    always @(posedge clk) begin
        logic [31:0] msk, wv, rise, clr;
        int idx;
        if (reset) begin
            m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_rdata = '0; m_irq = 1'b0;
            samp_q = '{32'h0, 32'h0, 32'h0};
        end else begin
            msk  = {{8{bus_if.be[3]}}, {8{bus_if.be[2]}}, {8{bus_if.be[1]}}, {8{bus_if.be[0]}}} & PIN_MASK;
            wv   = bus_if.wdata & msk;
            idx  = int'(bus_if.addr[11:2]);
            rise = samp_q[1] & ~samp_q[2];
            clr  = '0;
            if (!bus_if.cs_n && !bus_if.we) begin
                case (idx)
                    0: m_rdata = m_out;
                    1: m_rdata = m_dir;
                    2: m_rdata = samp_q[1];
                    3: m_rdata = m_en;
                    4: m_rdata = m_stat;
                    default: m_rdata = 32'h0;
                endcase
            end
            if (!bus_if.cs_n && bus_if.we) begin
                case (idx)
                    0: m_out = (m_out & ~msk) | wv;
                    1: m_dir = (m_dir & ~msk) | wv;
                    4: clr = wv;
                    5: m_out = m_out | wv;
                    6: m_out = m_out & ~wv;
                    default: ;
                endcase
            end
            m_stat = (rise & m_en) | (m_stat & ~clr);
            if (!bus_if.cs_n && bus_if.we && idx == 3) m_en = (m_en & ~msk) | wv;
            m_irq = |(m_stat & m_en);
            samp_q.push_front(32'(gpio_in));
            void'(samp_q.pop_back());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rdata", bus_if.rdata, m_rdata);
            check("model_gpio_out", 32'(gpio_out), m_out);
            check("model_gpio_oe", 32'(gpio_oe), m_dir);
            check("model_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        bus_if.cs_n = 1'b0; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d; bus_if.be = b;
        @(posedge clk);
        #1;
        bus_if.cs_n = 1'b1; bus_if.we = 1'b0;
        $display("WR  addr=%03h data=%08h be=%b", a, d, b);
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        bus_if.cs_n = 1'b0; bus_if.we = 1'b0; bus_if.addr = a;
        @(posedge clk);
        #1;
        bus_if.cs_n = 1'b1;
        d = bus_if.rdata;
        $display("RD  addr=%03h data=%08h", a, d);
    endtask

    logic [31:0] rd;

    initial begin
        reset = 1'b1;
        gpio_in = '0;
        bus_if.cs_n = 1'b1; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.be = '0; bus_if.wdata = '0;
        idle(2);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state and all offsets read zero
        check("reset_gpio_out", 32'(gpio_out), 32'h0);
        check("reset_gpio_oe", 32'(gpio_oe), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read(12'(i * 4), rd);
            check($sformatf("reset_read_%02h", i * 4), rd, 32'h0);
        end

        // Byte-masked write, then SET and CLR aliases
        bus_write(A_OUT, 32'h0000A5A5, 4'b0001);
        bus_read(A_OUT, rd);  check("out_be0", rd, 32'h000000A5);
        bus_write(A_SET, 32'h00000F00, 4'b1111);
        bus_read(A_OUT, rd);  check("out_set", rd, 32'h00000FA5);
        bus_write(A_CLR, 32'h00000005, 4'b1111);
        bus_read(A_OUT, rd);  check("out_clr", rd, 32'h00000FA0);
        check("gpio_out_pin", 32'(gpio_out), 32'h00000FA0);
        bus_read(A_SET, rd);  check("set_reads_0", rd, 32'h0);

        // Upper bits beyond N_GPIO are absent
        bus_write(A_DIR, 32'h0000FFFF, 4'b1111);
        bus_write(A_OUT, 32'hFFFFFFFF, 4'b1111);
        bus_read(A_OUT, rd);  check("out_width", rd, 32'h0000FFFF);
        check("gpio_oe_all", 32'(gpio_oe), 32'h0000FFFF);

        // Input synchronizer latency; disabled edge is dropped
        gpio_in = 16'h0001;
        bus_read(A_IN, rd);   check("in_lat1", rd, 32'h0);
        bus_read(A_IN, rd);   check("in_lat2", rd, 32'h0);
        bus_read(A_IN, rd);   check("in_lat3", rd, 32'h1);
        bus_read(A_STAT, rd); check("stat_disabled", rd, 32'h0);
        check("irq_disabled", 32'(irq), 32'h0);

        // Enabled edge, W1C, and W1C colliding with a new edge
        bus_write(A_EN, 32'h1, 4'b1111);
        gpio_in = '0;  idle(4);
        gpio_in = 16'h0001; idle(3);
        check("irq_set", 32'(irq), 32'h1);
        bus_read(A_STAT, rd); check("stat_set", rd, 32'h1);
        bus_write(A_STAT, 32'h1, 4'b1111);
        check("irq_w1c", 32'(irq), 32'h0);
        bus_read(A_STAT, rd); check("stat_w1c", rd, 32'h0);
        gpio_in = '0;  idle(4);
        gpio_in = 16'h0001; idle(2);
        bus_write(A_STAT, 32'h1, 4'b1111);
        check("irq_edge_wins", 32'(irq), 32'h1);
        bus_read(A_STAT, rd); check("stat_edge_wins", rd, 32'h1);
        bus_write(A_EN, 32'h0, 4'b1111);
        check("irq_masked", 32'(irq), 32'h0);
        bus_read(A_STAT, rd); check("stat_kept", rd, 32'h1);

        // Reset overriding a write and a read
        reset = 1'b1;
        bus_write(A_OUT, 32'h00005555, 4'b1111);
        reset = 1'b0;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        bus_read(A_OUT, rd);  check("rst_out_read", rd, 32'h0);
        bus_write(A_DIR, 32'h000000AB, 4'b1111);
        bus_read(A_DIR, rd);  check("dir_read", rd, 32'h000000AB);
        reset = 1'b1;
        bus_read(A_DIR, rd);  check("rst_rdata", rd, 32'h0);
        reset = 1'b0;

        // Randomized traffic; the per-cycle compare does the checking
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus_if.cs_n = ($urandom_range(0, 3) == 0);
            bus_if.we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                bus_if.addr = 12'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            else
                bus_if.addr = 12'($urandom);
            bus_if.be = 4'($urandom);
            bus_if.wdata = $urandom;
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ N_GPIO'($urandom);
            @(posedge clk);
            #1;
            if (n % 100 == 0)
                $display("RND %0d out=%04h oe=%04h irq=%0d rdata=%08h", n, gpio_out, gpio_oe, irq, bus_if.rdata);
        end
        bus_if.cs_n = 1'b1;
        reset = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
